// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 2-flop input sync, start-bit qualification,
// LSB-first data capture, stop-bit check and valid/ack delivery with overrun detect.
//
// state   | meaning
// S_IDLE  | line idle; arms on a high sample, starts on a low sample once armed
// S_START | counting to mid start bit to reject glitches
// S_DATA  | sampling one data bit every OVERSAMPLE ticks
// S_STOP  | sampling the stop bit; good frame delivered, bad frame flagged
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_tick, w_tick_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_armed, w_armed_nxt;
  logic                 r_sync, r_rx_s;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_ovr;
  logic                 w_stop_good, w_stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_sync <= rx;
      r_rx_s <= r_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    if (rx_en) begin
      case (r_state)
        S_IDLE: begin
          // A line that never returned high since the last bad stop stays ignored.
          if (r_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick == TICK_MID) begin
            if (!r_rx_s) begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_tick_nxt  = '0;
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == BIT_LAST) w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
            if (r_rx_s) begin
              w_stop_good = 1'b1;
            end else begin
              w_stop_bad  = 1'b1;
              w_armed_nxt = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // An ack in the stop-sample cycle frees the holding register for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_stop_good) begin
        if (!r_valid || rx_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model pushes expected
// deliveries/error pulses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DB = 8;
  localparam int EV_DATA = 0, EV_FERR = 1, EV_OVR = 2;

  logic          clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, rx = 1'b1, rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, framing_err, overrun, busy;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {int kind; logic [DB-1:0] data;} ev_t;
  ev_t exp_q[$];
  int tests = 0, fails = 0;
  int en_period = 27, en_cnt = 0;
  longint cyc = 0, start_cyc = 0, valid_rise_cyc = 0;
  bit m_pending = 0;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (en_cnt >= en_period - 1) begin en_cnt = 0; rx_en = 1'b1; end
    else begin en_cnt++; rx_en = 1'b0; end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic take(int kind, logic [DB-1:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_DATA && e.data !== d)) begin
        fails++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  logic          p_valid = 1'b0, p_ack = 1'b0;
  logic [DB-1:0] p_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
      p_ack   = 1'b0;
    end else begin
      if (rx_valid && (!p_valid || p_ack)) begin
        valid_rise_cyc = cyc;
        take(EV_DATA, rx_data);
      end else if (p_valid && !p_ack) begin
        chk("valid_hold", {31'd0, rx_valid}, 32'd1);
        chk("data_stable", {24'd0, rx_data}, {24'd0, p_data});
      end
      if (framing_err) take(EV_FERR, '0);
      if (overrun) take(EV_OVR, '0);
      p_valid = rx_valid;
      p_ack   = rx_ack;
      p_data  = rx_data;
    end
  end

  task automatic wait_tick(int n);
    repeat (n) begin
      @(posedge clk);
      while (rx_en !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_bits(logic v, int ticks);
    #2;
    rx = v;
    wait_tick(ticks);
  endtask

  task automatic idle(int bits);
    drive_bits(1'b1, 16 * bits);
  endtask

  // Stop sample lands on tick 8 + 16*DB + 16 after the start is recognised.
  task automatic ack_at_stop();
    int n = 0;
    while (!busy && n < 3000) begin @(negedge clk); n++; end
    if (!busy) begin
      fails++;
      $display("FAIL busy_timeout: got busy 0 expected 1");
    end else begin
      wait_tick(8 + 16 * DB + 16 - 1);
      #2;
      while (!rx_en) begin @(posedge clk); #2; end
      rx_ack = 1'b1;
      @(posedge clk);
      #2;
      rx_ack = 1'b0;
    end
  endtask

  task automatic send_frame(logic [DB-1:0] d, logic stop, bit ack_stop);
    fork
      begin
        start_cyc = cyc;
        drive_bits(1'b0, 16);
        for (int i = 0; i < DB; i++) drive_bits(d[i], 16);
        if (ack_stop) m_pending = 0;
        if (!stop) exp_q.push_back('{EV_FERR, '0});
        else if (m_pending) exp_q.push_back('{EV_OVR, '0});
        else begin
          exp_q.push_back('{EV_DATA, d});
          m_pending = 1;
        end
        drive_bits(stop, 16);
      end
      begin
        if (ack_stop) ack_at_stop();
      end
    join
  endtask

  task automatic do_ack();
    int n = 0;
    while (!rx_valid && n < 20000) begin @(negedge clk); n++; end
    if (!rx_valid) begin
      fails++;
      $display("FAIL ack_timeout: got rx_valid 0 expected 1");
    end else begin
      @(posedge clk); #2; rx_ack = 1'b1;
      @(posedge clk); #2; rx_ack = 1'b0;
      m_pending = 0;
      @(negedge clk);
      chk("valid_clear", {31'd0, rx_valid}, 32'd0);
    end
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_data"}, {24'd0, rx_data}, 32'd0);
    chk({name, "_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({name, "_flags"}, {29'd0, framing_err, overrun, busy}, 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] d, pat;
    logic stop;
    int pol;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Test 1: single frame, latency ~9.5 bits
    idle(1);
    send_frame(8'hA5, 1'b1, 0);
    chk("t1_data", {24'd0, rx_data}, 32'hA5);
    chk("t1_latency", {31'd0, ((valid_rise_cyc - start_cyc) >= 4050 &&
                               (valid_rise_cyc - start_cyc) <= 4200)}, 32'd1);
    do_ack();

    // Test 2: back-to-back frames with concurrent acks
    idle(1);
    fork
      begin send_frame(8'h00, 1'b1, 0); send_frame(8'hFF, 1'b1, 0); end
      begin do_ack(); do_ack(); end
    join

    // Test 3: short low glitch
    idle(1);
    drive_bits(1'b0, 4);
    @(negedge clk);
    chk("t3_busy_high", {31'd0, busy}, 32'd1);
    idle(1);
    @(negedge clk);
    chk("t3_busy_low", {31'd0, busy}, 32'd0);
    chk("t3_valid", {31'd0, rx_valid}, 32'd0);

    // Test 4: framing error, held-low line, then recovery
    send_frame(8'h3C, 1'b0, 0);
    chk("t4_valid", {31'd0, rx_valid}, 32'd0);
    drive_bits(1'b0, 48);
    idle(1);
    send_frame(8'h12, 1'b1, 0);
    chk("t4_data", {24'd0, rx_data}, 32'h12);
    do_ack();

    // Test 5: overrun, then ack in the stop-sample cycle
    idle(1);
    send_frame(8'h55, 1'b1, 0);
    idle(1);
    send_frame(8'h66, 1'b1, 0);
    chk("t5_keep", {24'd0, rx_data}, 32'h55);
    idle(1);
    send_frame(8'h66, 1'b1, 1);
    chk("t5_new", {24'd0, rx_data}, 32'h66);
    chk("t5_valid", {31'd0, rx_valid}, 32'd1);
    do_ack();

    // Test 6: reset mid data bit 4 with a byte pending
    idle(1);
    send_frame(8'h42, 1'b1, 0);
    idle(1);
    pat = 8'h81;
    drive_bits(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bits(pat[i], 16);
    drive_bits(pat[4], 8);
    #2 rst_n = 1'b0;
    m_pending = 0;
    #1;
    check_all_zero("t6_reset");
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    send_frame(8'h81, 1'b1, 0);
    chk("t6_data", {24'd0, rx_data}, 32'h81);
    do_ack();

    // Randomized frames at faster tick rates
    for (int k = 0; k < 16; k++) begin
      en_period = $urandom_range(1, 3);
      d = DB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pol = $urandom_range(0, 2);
      idle(1 + $urandom_range(0, 1));
      send_frame(d, stop, pol == 2);
      if (pol == 0 && m_pending) do_ack();
    end
    idle(1);
    if (m_pending) do_ack();

    repeat (20) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: 8N1 by default, LSB first, 16x oversampled.
- Consumes the 16x-oversample tick (rx_en) from the baud generator and the raw rx pin.
- Delivers bytes to the parallel side through a valid/ack handshake.
- Sits between the pad/baud generator and the host-side consumer (FIFO or controller).

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, rx_en ticks per bit period; fixed at 16 for this block, counter width is 4 bits.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- rx_en  in  1  one-clk pulse, 16 per bit period, from the baud generator.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  last received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer has taken rx_data.
- framing_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: frame completed while rx_valid=1 and no rx_ack.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - rx_data=0, rx_valid=0, framing_err=0, overrun=0, busy=0.
  - State=IDLE, counters=0, armed=0.
  - Synchronizer flops=1.
- Input sync: 2-flop synchronizer on rx gives rx_s. All logic uses rx_s.
- State advance: state, tick counter (tick_cnt, 4 bit) and bit counter (bit_cnt) change only on cycles with rx_en=1. The handshake logic runs every clk.
- IDLE:
  - On rx_en with rx_s=1, set armed=1.
  - On rx_en with rx_s=0 and armed=1, go to START with tick_cnt=0.
  - If armed=0, a low line is ignored. This blocks retriggering on a held-low/break line.
- START:
  - tick_cnt increments each rx_en.
  - On the rx_en where tick_cnt==7 (mid start bit):
    - rx_s=0 → DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1 → glitch; go to IDLE, armed stays 1.
- DATA:
  - On the rx_en where tick_cnt==15, sample rx_s into the shift register (shift right, new bit in at MSB, so LSB first). tick_cnt wraps to 0 and bit_cnt increments.
  - After bit DATA_BITS-1 is sampled, go to STOP.
- STOP: on the rx_en where tick_cnt==15:
  - rx_s=1 → frame good; go to IDLE.
  - rx_s=0 → framing_err=1 for exactly one clk, frame discarded, armed=0; go to IDLE.
- Delivery of a good frame (registered, the clk after the stop-sample cycle):
  - If rx_valid=0, or rx_ack=1 in the stop-sample cycle: rx_data←shift register, rx_valid=1.
  - Otherwise: rx_data and rx_valid are unchanged, the new byte is dropped, and overrun=1 for one clk.
- Handshake:
  - rx_valid clears the clk after rx_ack=1 is sampled while rx_valid=1.
  - rx_ack while rx_valid=0 has no effect.
  - rx_data is stable while rx_valid=1.
- Reset mid-frame: all state returns to reset values immediately. Any partial frame is lost and no pulse is emitted.
- rx_en held high continuously is legal: the block simply runs at clk rate.

Test Plan:
- Setup for all tests: clk 50 MHz; rx_en every 27 clks (one bit = 432 clks).
- Test 1: idle high 1 bit, then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → rx_valid rises ~9.5 bit times after the start edge, rx_data=0xA5, framing_err=0. Assert rx_ack one clk → rx_valid=0 next clk.
- Test 2: 0x00 then 0xFF back-to-back, with rx_ack after each → two deliveries, 0x00 then 0xFF, no error pulses.
- Test 3: low glitch of 4 rx_en ticks (108 clks) on an idle line → stays IDLE after the mid-start check, rx_valid stays 0, busy pulses then clears.
- Test 4: frame 0x3C with stop bit driven low → framing_err one-clk pulse, rx_valid=0. Line held low 3 more bit times, then high, then frame 0x12 → no false frames during the low period; rx_data=0x12.
- Test 5: frame 0x55 left unacked, then frame 0x66 → overrun one-clk pulse, rx_data remains 0x55. Repeat with rx_ack asserted in the stop-sample cycle → rx_data=0x66, no overrun.
- Test 6: assert rst_n=0 mid data bit 4 of a frame → all outputs 0 immediately. After release, a clean frame 0x81 is received correctly.
